id_ex_reg: RTL and testbench
============================

# id_ex_reg

Pipeline register between the decode stage and the execute stage of the 5-stage core. It captures decoded operands, immediates, register indices and control fields (including `alu_op`, `funct3`, `funct7` consumed by the ALU control decoder) and presents them to EX one cycle later. It implements stall (hold), flush (bubble insertion) and operand isolation, which holds data fields when no valid instruction is loaded, to cut EX-stage toggling. A saturating bubble counter supports power/CPI analysis.

## Interface
- `XLEN`, 32: datapath width.
- `CNT_W`, 32: bubble counter width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all contents (from hazard unit).
- `flush`  in  1  insert bubble (branch taken / load-use).
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  XLEN  instruction PC.
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices.
- `id_funct3`  in  3; `id_funct7`  in  7  instruction fields.
- `id_alu_op`  in  2  00 add, 01 sub/branch, 10 R-type, 11 I-type.
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch`  in  1 each  control bits.
- `ex_valid`  out  1; all `ex_*` counterparts of the above `id_*` fields  out  same widths.
- `bubble_cnt`  out  CNT_W  cycles in which a bubble was loaded.

## Operation
- Field groups: CTRL = {valid, alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}; DATA = {pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7}.
- Per-cycle priority: `rst` > `flush` > `stall` > load.
  - rst: every output, including `bubble_cnt`, becomes 0.
  - flush: CTRL all 0 (alu_op = 00), DATA hold, `bubble_cnt` +1.
  - stall (no flush): CTRL and DATA hold, counter unchanged.
  - load, `id_valid`=1: CTRL and DATA take the `id_*` values, `ex_valid`=1.
  - load, `id_valid`=0: CTRL all 0, DATA hold (operand isolation), `bubble_cnt` +1.
- Flush together with stall yields a bubble. The flush wins because the wrong-path instruction must die.
- A bubble must never cause a write: when `ex_valid`=0, then `ex_reg_write`, `ex_mem_write`, `ex_mem_read` and `ex_branch` are all 0.
- `bubble_cnt` saturates at all-ones and does not wrap.
- `id_rd`=0 with `id_reg_write`=1 is passed through unchanged. Suppressing the x0 write belongs to WB/the register file.

## Timing
- Latency is 1 cycle. Values present on `id_*` at edge N appear on `ex_*` after edge N. No combinational path from any input to any output.
- `stall` and `flush` are sampled at the same edge as the data.
- After reset deassertion, the first edge with `id_valid`=1 and neither stall nor flush loads an instruction.
- Reset asserted mid-stall or mid-flush clears everything at that edge. Reset takes priority.
- A stall held for K cycles keeps the outputs bit-identical for K cycles.

## Structure
- Shared package `core_pkg` holds:
  - `XLEN`;
  - the `alu_op` encodings as named constants (ALUOP_ADD=2'b00, ALUOP_BR=2'b01, ALUOP_R=2'b10, ALUOP_I=2'b11);
  - a packed `ctrl_t` struct/bundle for CTRL, reused by the EX/MEM and MEM/WB registers.
- One natural sub-module: `pipe_field_reg`, a parameterised-width register with `hold` and `clr` inputs. It is instantiated once for CTRL (clr on bubble) and once for DATA (never clears except on reset, and holds on bubble).
- The counter stays inline.

## Test plan
- Reset: drive all `id_*` to nonzero and `rst`=1 for 2 cycles. Required: every `ex_*` = 0 and `bubble_cnt` = 0.
- Load: `id_valid`=1, pc=0x0000_0010, rs1_data=0x5, imm=0xFFFF_FFFC, alu_op=10, funct3=000, funct7=0100000. Required: identical values on `ex_*` one cycle later and `ex_valid`=1.
- Stall: load the instruction above, then stall for 3 cycles while changing `id_*`. Required: `ex_*` unchanged for those 3 cycles, then the new values load on the first unstalled edge.
- Flush plus stall in the same cycle with a valid instruction loaded. Required: `ex_valid`=0, `ex_reg_write`=0, `ex_alu_op`=00, `ex_rs1_data` still 0x5, `bubble_cnt` incremented by 1.
- Invalid input for 4 cycles (`id_valid`=0 with random DATA). Required: DATA outputs hold the previous values, CTRL = 0, `bubble_cnt` incremented by 4.
- Saturation: with `CNT_W`=4, feed 20 bubble cycles. Required: `bubble_cnt` stops at 15 and stays there.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_pkg                                                           |
// | Shared core types: datapath width, ALU-op codes, CTRL bundle.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // Control bundle carried down the pipe; all-zero is a harmless bubble.
  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage
`default_nettype wire

// File: rtl/pipe_field_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_field_reg                                                     |
// | Pipeline field register with hold and clear (rst > clr > hold).    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (!hold) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_reg                                                          |
// | ID/EX pipeline register: stall, flush, operand isolation, bubble   |
// | counter. Revision: 1.0                                             |
// +--------------------------------------------------------------------+
module id_ex_reg import core_pkg::*; #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int c_DATA_W = 4*XLEN + 3*5 + 3 + 7;

  ctrl_t               w_ctrl_d;
  ctrl_t               w_ctrl_q;
  logic [c_DATA_W-1:0] w_data_d;
  logic [c_DATA_W-1:0] w_data_q;
  logic                w_bubble;
  logic [CNT_W-1:0]    r_bubble_cnt;

  // A flush kills the slot even under stall; an empty ID slot also
  // becomes a bubble unless the stage is stalled.
  assign w_bubble = flush | (~stall & ~id_valid);

  assign w_ctrl_d = '{valid:      id_valid,
                      alu_op:     id_alu_op,
                      alu_src:    id_alu_src,
                      mem_read:   id_mem_read,
                      mem_write:  id_mem_write,
                      reg_write:  id_reg_write,
                      mem_to_reg: id_mem_to_reg,
                      branch:     id_branch};

  assign w_data_d = {id_pc, id_rs1_data, id_rs2_data, id_imm,
                     id_rs1, id_rs2, id_rd, id_funct3, id_funct7};

  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk  (clk),
    .rst  (rst),
    .hold (stall),
    .clr  (w_bubble),
    .d    (w_ctrl_d),
    .q    (w_ctrl_q)
  );

  // Data is frozen on bubbles so EX operands do not toggle.
  pipe_field_reg #(.W(c_DATA_W)) u_data_reg (
    .clk  (clk),
    .rst  (rst),
    .hold (stall | w_bubble),
    .clr  (1'b0),
    .d    (w_data_d),
    .q    (w_data_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid      = w_ctrl_q.valid;
  assign ex_alu_op     = w_ctrl_q.alu_op;
  assign ex_alu_src    = w_ctrl_q.alu_src;
  assign ex_mem_read   = w_ctrl_q.mem_read;
  assign ex_mem_write  = w_ctrl_q.mem_write;
  assign ex_reg_write  = w_ctrl_q.reg_write;
  assign ex_mem_to_reg = w_ctrl_q.mem_to_reg;
  assign ex_branch     = w_ctrl_q.branch;

  assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
          ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7} = w_data_q;

  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_ex_reg                                                       |
// | Self-checking bench for id_ex_reg (32-bit and 4-bit counter DUTs). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } fields_t;

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] pc, rs1d;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        e_valid;
    logic [31:0] e_pc, e_rs1d;
    logic [1:0]  e_alu_op;
    logic        e_reg_write;
    int          e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  fields_t     id_f = '0;
  wire fields_t ex_f;
  wire fields_t ex_s;
  wire [31:0]  cnt;
  wire [3:0]   cnt_s;

  fields_t     m;
  int unsigned mcnt;
  int          checks = 0;
  int          errors = 0;
  vec_t        vq[$];

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_f.valid), .id_pc(id_f.pc), .id_rs1_data(id_f.rs1_data),
    .id_rs2_data(id_f.rs2_data), .id_imm(id_f.imm), .id_rs1(id_f.rs1),
    .id_rs2(id_f.rs2), .id_rd(id_f.rd), .id_funct3(id_f.funct3),
    .id_funct7(id_f.funct7), .id_alu_op(id_f.alu_op), .id_alu_src(id_f.alu_src),
    .id_mem_read(id_f.mem_read), .id_mem_write(id_f.mem_write),
    .id_reg_write(id_f.reg_write), .id_mem_to_reg(id_f.mem_to_reg),
    .id_branch(id_f.branch),
    .ex_valid(ex_f.valid), .ex_pc(ex_f.pc), .ex_rs1_data(ex_f.rs1_data),
    .ex_rs2_data(ex_f.rs2_data), .ex_imm(ex_f.imm), .ex_rs1(ex_f.rs1),
    .ex_rs2(ex_f.rs2), .ex_rd(ex_f.rd), .ex_funct3(ex_f.funct3),
    .ex_funct7(ex_f.funct7), .ex_alu_op(ex_f.alu_op), .ex_alu_src(ex_f.alu_src),
    .ex_mem_read(ex_f.mem_read), .ex_mem_write(ex_f.mem_write),
    .ex_reg_write(ex_f.reg_write), .ex_mem_to_reg(ex_f.mem_to_reg),
    .ex_branch(ex_f.branch), .bubble_cnt(cnt)
  );

  id_ex_reg #(.XLEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_f.valid), .id_pc(id_f.pc), .id_rs1_data(id_f.rs1_data),
    .id_rs2_data(id_f.rs2_data), .id_imm(id_f.imm), .id_rs1(id_f.rs1),
    .id_rs2(id_f.rs2), .id_rd(id_f.rd), .id_funct3(id_f.funct3),
    .id_funct7(id_f.funct7), .id_alu_op(id_f.alu_op), .id_alu_src(id_f.alu_src),
    .id_mem_read(id_f.mem_read), .id_mem_write(id_f.mem_write),
    .id_reg_write(id_f.reg_write), .id_mem_to_reg(id_f.mem_to_reg),
    .id_branch(id_f.branch),
    .ex_valid(ex_s.valid), .ex_pc(ex_s.pc), .ex_rs1_data(ex_s.rs1_data),
    .ex_rs2_data(ex_s.rs2_data), .ex_imm(ex_s.imm), .ex_rs1(ex_s.rs1),
    .ex_rs2(ex_s.rs2), .ex_rd(ex_s.rd), .ex_funct3(ex_s.funct3),
    .ex_funct7(ex_s.funct7), .ex_alu_op(ex_s.alu_op), .ex_alu_src(ex_s.alu_src),
    .ex_mem_read(ex_s.mem_read), .ex_mem_write(ex_s.mem_write),
    .ex_reg_write(ex_s.reg_write), .ex_mem_to_reg(ex_s.mem_to_reg),
    .ex_branch(ex_s.branch), .bubble_cnt(cnt_s)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: an instruction slot either dies (control zeroed, operands
  // kept, one more bubble), freezes, or takes the ID contents wholesale.
  task automatic model_step();
    if (rst) begin
      m = '0;
      mcnt = 0;
    end else if (flush || (!stall && !id_f.valid)) begin
      m.valid = 0; m.alu_op = 0; m.alu_src = 0; m.mem_read = 0;
      m.mem_write = 0; m.reg_write = 0; m.mem_to_reg = 0; m.branch = 0;
      if (mcnt != 32'hFFFF_FFFF) mcnt++;
    end else if (!stall) begin
      m = id_f;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    int unsigned sat;
    sat = (mcnt > 15) ? 15 : mcnt;
    check({tag, " fields"}, ex_f, m);
    check({tag, " fields4"}, ex_s, m);
    check({tag, " cnt"}, cnt, mcnt);
    check({tag, " cnt4"}, cnt_s, sat);
    if (!ex_f.valid)
      check({tag, " nowrite"}, {ex_f.reg_write, ex_f.mem_write, ex_f.mem_read, ex_f.branch}, 0);
  endtask

  function automatic fields_t rand_fields();
    fields_t f;
    f = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return f;
  endfunction

  task automatic add(input logic r, s, fl, v, input logic [31:0] pc, rs1d, input logic [1:0] op,
                     input logic rw, input logic ev, input logic [31:0] epc, ers1d,
                     input logic [1:0] eop, input logic erw, input int ecnt);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = fl; t.valid = v; t.pc = pc; t.rs1d = rs1d;
    t.alu_op = op; t.reg_write = rw; t.e_valid = ev; t.e_pc = epc; t.e_rs1d = ers1d;
    t.e_alu_op = eop; t.e_reg_write = erw; t.e_cnt = ecnt;
    vq.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    fields_t ld;
    m = '0;
    mcnt = 0;
    //   rst stl fl  v  pc      rs1d   op  rw | ev  pc      rs1d   op  rw cnt
    add(1, 0, 0, 1, 32'h100, 32'h11, 2'd3, 1, 0, 32'h0,  32'h0,  2'd0, 0, 0);
    add(1, 0, 0, 1, 32'h100, 32'h11, 2'd3, 1, 0, 32'h0,  32'h0,  2'd0, 0, 0);
    add(0, 0, 0, 1, 32'h10,  32'h5,  2'd2, 1, 1, 32'h10, 32'h5,  2'd2, 1, 0);
    add(0, 1, 0, 1, 32'h20,  32'h7,  2'd3, 0, 1, 32'h10, 32'h5,  2'd2, 1, 0);
    add(0, 1, 0, 1, 32'h24,  32'h8,  2'd1, 0, 1, 32'h10, 32'h5,  2'd2, 1, 0);
    add(0, 1, 0, 0, 32'h28,  32'h9,  2'd0, 0, 1, 32'h10, 32'h5,  2'd2, 1, 0);
    add(0, 0, 0, 1, 32'h20,  32'h7,  2'd3, 0, 1, 32'h20, 32'h7,  2'd3, 0, 0);
    add(0, 0, 0, 1, 32'h10,  32'h5,  2'd2, 1, 1, 32'h10, 32'h5,  2'd2, 1, 0);
    add(0, 1, 1, 1, 32'h30,  32'h9,  2'd2, 1, 0, 32'h10, 32'h5,  2'd0, 0, 1);
    add(0, 0, 0, 0, 32'h40,  32'hA,  2'd2, 1, 0, 32'h10, 32'h5,  2'd0, 0, 2);
    add(0, 0, 0, 0, 32'h44,  32'hB,  2'd3, 1, 0, 32'h10, 32'h5,  2'd0, 0, 3);
    add(0, 0, 0, 0, 32'h48,  32'hC,  2'd1, 1, 0, 32'h10, 32'h5,  2'd0, 0, 4);
    add(0, 0, 0, 0, 32'h4C,  32'hD,  2'd2, 1, 0, 32'h10, 32'h5,  2'd0, 0, 5);
    add(0, 0, 0, 1, 32'h44,  32'hB,  2'd1, 0, 1, 32'h44, 32'hB,  2'd1, 0, 5);
    add(1, 0, 1, 1, 32'h50,  32'hE,  2'd2, 1, 0, 32'h0,  32'h0,  2'd0, 0, 0);
    add(0, 0, 1, 1, 32'h54,  32'hF,  2'd2, 1, 0, 32'h0,  32'h0,  2'd0, 0, 1);

    foreach (vq[i]) begin
      rst = vq[i].rst; stall = vq[i].stall; flush = vq[i].flush;
      id_f = '1;
      id_f.valid = vq[i].valid; id_f.pc = vq[i].pc; id_f.rs1_data = vq[i].rs1d;
      id_f.alu_op = vq[i].alu_op; id_f.reg_write = vq[i].reg_write;
      step();
      check($sformatf("vec%0d valid", i), ex_f.valid, vq[i].e_valid);
      check($sformatf("vec%0d pc", i), ex_f.pc, vq[i].e_pc);
      check($sformatf("vec%0d rs1_data", i), ex_f.rs1_data, vq[i].e_rs1d);
      check($sformatf("vec%0d alu_op", i), ex_f.alu_op, vq[i].e_alu_op);
      check($sformatf("vec%0d reg_write", i), ex_f.reg_write, vq[i].e_reg_write);
      check($sformatf("vec%0d bubble_cnt", i), cnt, vq[i].e_cnt);
      if (vq[i].rst) check($sformatf("vec%0d reset zero", i), ex_f, 0);
      check_model($sformatf("vec%0d", i));
    end

    // Load of the reference instruction, then a 3-cycle stall with churn.
    rst = 1; flush = 0; stall = 0; id_f = rand_fields();
    step();
    rst = 0;
    ld = rand_fields();
    ld.valid = 1; ld.pc = 32'h10; ld.rs1_data = 32'h5; ld.imm = 32'hFFFF_FFFC;
    ld.alu_op = 2'b10; ld.funct3 = 3'b000; ld.funct7 = 7'b0100000;
    ld.rd = 5'd0; ld.reg_write = 1;
    id_f = ld;
    step();
    check("load imm", ex_f.imm, 32'hFFFF_FFFC);
    check("load funct7", ex_f.funct7, 7'b0100000);
    check("load x0 write", {ex_f.valid, ex_f.rd, ex_f.reg_write}, {1'b1, 5'd0, 1'b1});
    check("load all", ex_f, ld);
    for (int k = 0; k < 3; k++) begin
      stall = 1; id_f = rand_fields();
      step();
      check($sformatf("stall%0d hold", k), ex_f, ld);
      check_model($sformatf("stall%0d", k));
    end
    stall = 0; id_f = rand_fields(); id_f.valid = 1; ld = id_f;
    step();
    check("unstall load", ex_f, ld);

    // Saturation of the 4-bit counter over 20 bubbles.
    rst = 1;
    step();
    rst = 0;
    for (int k = 1; k <= 20; k++) begin
      id_f = rand_fields(); id_f.valid = 0;
      step();
      check($sformatf("sat%0d cnt4", k), cnt_s, (k > 15) ? 15 : k);
      check($sformatf("sat%0d cnt", k), cnt, k);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      id_f  = rand_fields();
      id_f.valid = ($urandom_range(0, 3) != 0);
      step();
      check_model($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
